// File: rtl/cam_capture_writer.sv
// Camera capture writer: samples an OV7670-style RGB444 port in the clk domain, decimates by
// 2**c_decim_shift and emits single-cycle frame-buffer writes. Define CAM_CAPTURE_GRAY_EN for grayscale output.
module cam_capture_writer #(
  parameter int c_src_cols    = 640,
  parameter int c_src_rows    = 480,
  parameter int c_decim_shift = 3,
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     capture,
  input  logic                     cam_pclk,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_d,
  output logic                     wr_en,
  output logic [c_nb_img_pxls-1:0] wr_addr,
  output logic [11:0]              wr_data,
  output logic                     frame_done,
  output logic                     busy
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_FRAME = 1'b1;
  localparam logic [10:0] c_x_lim = 11'(c_src_cols);
  localparam logic [9:0]  c_y_lim = 10'(c_src_rows);
  localparam logic [c_nb_img_pxls:0] c_addr_lim = (c_nb_img_pxls+1)'(c_img_cols * c_img_rows);

  // {pclk, vsync, href, d} through two sync flops, then one registered edge-detect stage
  logic [10:0] sync1, sync2;
  logic [2:0]  prev;
  logic        pclk_rise_q, vs_rise_q, vs_fall_q, href_fall_q, href_q;
  logic [7:0]  d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      pclk_rise_q <= 1'b0;
      vs_rise_q   <= 1'b0;
      vs_fall_q   <= 1'b0;
      href_fall_q <= 1'b0;
      href_q      <= 1'b0;
      d_q         <= '0;
    end else begin
      sync1       <= {cam_pclk, cam_vsync, cam_href, cam_d};
      sync2       <= sync1;
      prev        <= sync2[10:8];
      pclk_rise_q <= sync2[10] & ~prev[2];
      vs_rise_q   <= sync2[9] & ~prev[1];
      vs_fall_q   <= ~sync2[9] & prev[1];
      href_fall_q <= ~sync2[8] & prev[0];
      href_q      <= sync2[8];
      d_q         <= sync2[7:0];
    end
  end

  logic        state;
  logic [10:0] x;
  logic [9:0]  y;
  logic        phase;
  logic [3:0]  r;
  logic        wr_ok;
  logic [11:0] pix;

  // Counters saturate so oversize lines/frames can never wrap back into the write window
  assign wr_ok = (x[c_decim_shift-1:0] == '0) && (y[c_decim_shift-1:0] == '0) &&
                 (x < c_x_lim) && (y < c_y_lim) && ({1'b0, wr_addr} < c_addr_lim);

`ifdef CAM_CAPTURE_GRAY_EN
  logic [3:0] gray;
  assign gray = 4'((6'(r) + {1'b0, d_q[7:4], 1'b0} + 6'(d_q[3:0])) >> 2);
  assign pix  = {gray, gray, gray};
`else
  assign pix  = {r, d_q};
`endif

  assign busy = (state == ST_FRAME);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      r          <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (state == ST_IDLE) begin
        if (vs_fall_q && capture) begin
          state   <= ST_FRAME;
          x       <= '0;
          y       <= '0;
          phase   <= 1'b0;
          wr_addr <= '0;
        end
      end else begin
        if (vs_rise_q) begin
          frame_done <= 1'b1;
          state      <= ST_IDLE;
        end else if (href_fall_q) begin
          if (y != '1) y <= y + 10'd1;
          x     <= '0;
          phase <= 1'b0;
        end else if (pclk_rise_q && href_q) begin
          if (!phase) begin
            r     <= d_q[3:0];
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (x != '1) x <= x + 11'd1;
            if (wr_ok) begin
              wr_en   <= 1'b1;
              wr_data <= pix;
            end
          end
        end
      end
    end
  end

endmodule
